// File: rtl/inst_decode_queue.sv
// Instruction decode queue: decodes RV32I fetch words at enqueue and buffers the decoded
// fields in a 2**DEPTH_LOG entry FIFO. Define DECODE_ILLEGAL_CHECK_EN to flag illegal opcodes.
module inst_decode_queue #(
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_jump,
    output logic        out_illegal
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        jump;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
        entry_t e;
        e.pc       = pc;
        e.opcode   = inst[6:0];
        e.funct3   = inst[14:12];
        e.funct7b5 = inst[30];
        e.rd       = inst[11:7];
        e.rs1      = inst[19:15];
        e.rs2      = 5'd0;
        e.imm      = 32'd0;
        e.jump     = 1'b0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                e.imm = {inst[31:12], 12'b0};
                e.rs1 = 5'd0;
            end
            OP_JAL: begin
                e.imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                e.rs1  = 5'd0;
                e.jump = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                e.imm = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                e.rd  = 5'd0;
                e.rs2 = inst[24:20];
            end
            OP_BRANCH: begin
                e.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                e.rd  = 5'd0;
                e.rs2 = inst[24:20];
            end
            OP_REG: begin
                e.rs2 = inst[24:20];
            end
            default: begin
                e.imm = 32'd0;
            end
        endcase
        return e;
    endfunction

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 enq, deq;
    entry_t               mem [DEPTH];
    entry_t               enq_entry;
    entry_t               head_entry;

    assign if_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    // Flush wins over both handshakes, so a flushed-cycle offer is never written.
    assign enq       = if_valid && if_ready && rdy && !flush;
    assign deq       = out_valid && out_ready && rdy && !flush;
    assign enq_entry = decode(if_inst, if_pc);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + DEPTH_LOG'(1);
            if (deq) head_d = head_q + DEPTH_LOG'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
                2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; out_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (enq) mem[tail_q] <= enq_entry;
    end

    assign head_entry   = mem[head_q];
    assign out_pc       = head_entry.pc;
    assign out_opcode   = head_entry.opcode;
    assign out_funct3   = head_entry.funct3;
    assign out_funct7b5 = head_entry.funct7b5;
    assign out_rd       = head_entry.rd;
    assign out_rs1      = head_entry.rs1;
    assign out_rs2      = head_entry.rs2;
    assign out_imm      = head_entry.imm;
    assign out_jump     = head_entry.jump;

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic ill_mem [DEPTH];
    logic enq_illegal;

    // Any word with inst[1:0] != 2'b11 also misses every opcode below.
    always_comb begin
        case (if_inst[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: enq_illegal = (if_inst[1:0] != 2'b11);
            default:                            enq_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) ill_mem[tail_q] <= enq_illegal;
    end

    assign out_illegal = ill_mem[head_q];
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 2, meaning queue depth = 2**DEPTH_LOG entries.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rdy  input  1  global enable; low means all state is frozen.
REQ-005 SHALL have port if_valid  input  1  the fetch stage offers an instruction.
REQ-006 SHALL have port if_inst  input  32  the raw instruction word.
REQ-007 SHALL have port if_pc  input  32  the instruction address.
REQ-008 SHALL have port if_ready  output  1  the queue can accept; equals not-full.
REQ-009 SHALL have port flush  input  1  discards all queued entries (mispredict or jump redirect).
REQ-010 SHALL have port out_valid  output  1  the head entry is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the head entry.
REQ-012 SHALL have outputs out_pc[32], out_opcode[7], out_funct3[3], out_funct7b5[1], out_rd[5], out_rs1[5], out_rs2[5], out_imm[32], out_jump[1] and out_illegal[1], carrying the decoded head fields.

Function
REQ-013 SHALL decode at enqueue and store pc, opcode, funct3, inst[30], rd, rs1, rs2, imm, jump and illegal per entry.
REQ-014 SHALL build the immediate by format: U (LUI/AUIPC) {inst[31:12],12'b0}; J (JAL) sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}; I (JALR/LOAD/OP-IMM) sign-extended inst[31:20]; S {inst[31:25],inst[11:7]} sign-extended; B {inst[31],inst[7],inst[30:25],inst[11:8],0} sign-extended; R 0.
REQ-015 SHALL force rd=0 for S/B; rs1=0 for LUI/AUIPC/JAL; rs2=0 for all formats other than S/B/R.
REQ-016 SHALL set jump=1 only for JAL.
REQ-017 SHALL treat the handshakes as follows: enqueue when if_valid && if_ready && rdy; dequeue when out_valid && out_ready && rdy.
REQ-018 SHALL make if_ready depend only on the occupancy count, never on out_ready (no combinational path); when the queue is full, a simultaneous enqueue and dequeue SHALL NOT enqueue.
REQ-019 SHALL have no bypass: an instruction accepted in cycle N appears at the outputs no earlier than cycle N+1.
REQ-020 SHALL support simultaneous enqueue and dequeue when not full and not empty, with the count unchanged.
REQ-021 SHALL use head and tail pointers of DEPTH_LOG bits that wrap modulo depth, and a count of DEPTH_LOG+1 bits.
REQ-022 SHALL NOT overflow: count never exceeds depth and never underflows; FIFO order is preserved.
REQ-023 SHALL, on flush && rdy, zero count and both pointers at the next edge; flush overrides an enqueue or dequeue in the same cycle, and the flushed-cycle enqueue is dropped.
REQ-024 SHALL, when rdy=0, hold pointers, count and storage; flush and both handshakes are ignored.
REQ-025 SHALL drive out_valid = (count != 0) and the out_* fields from the head entry; the out_* fields are don't-care when out_valid=0.

Reset
REQ-026 SHALL, on rst, asynchronously clear count, head and tail to 0.
REQ-027 SHALL hold, during reset, out_valid=0 and if_ready=1; storage contents need not be cleared.
REQ-028 SHALL, if reset is asserted mid-operation, discard all entries; the first post-reset enqueue lands in entry 0.

Configuration
REQ-029 SHALL use macro DECODE_ILLEGAL_CHECK_EN: when defined, illegal=1 if inst[1:0]!=2'b11 or the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM or OP.
REQ-030 SHALL, without DECODE_ILLEGAL_CHECK_EN, tie out_illegal to 0 and decode unknown opcodes with imm=0 and jump=0.

Verification
REQ-031 SHALL cover: enqueue 0x0080006F at pc 0x100 -> next cycle out_valid=1, out_jump=1, out_imm=0x00000008, out_rd=0, out_rs1=0.
REQ-032 SHALL cover: enqueue 0xFE208EE3 (beq x1,x2,-4) -> out_imm=0xFFFFFFFC, out_rs1=1, out_rs2=2, out_rd=0, out_jump=0.
REQ-033 SHALL cover: DEPTH_LOG=2, out_ready=0, five offers -> if_ready=0 after the 4th accept and the 5th is held; with out_ready=1, the pcs drain in order and wrap correctly.
REQ-034 SHALL cover: 3 entries queued, flush=1 with if_valid=1 in the same cycle -> next cycle out_valid=0, if_ready=1, and the offered instruction is not enqueued.
REQ-035 SHALL cover: 2 entries queued, rdy=0 for 3 cycles with out_ready=1 and flush=1 -> no pop and the head is unchanged; after rdy=1, pops resume.
REQ-036 SHALL cover: enqueue 0x0000007F -> out_illegal=1 with DECODE_ILLEGAL_CHECK_EN and 0 without; rst pulsed mid-stream -> out_valid=0 immediately (asynchronously).
